data_bus_demux: RTL and testbench
=================================

# data_bus_demux

Routes a single-master CPU load/store request to one of two slave ports (data memory or I/O) by one address bit, waits for the selected slave's acknowledge, and returns the read data and completion to the CPU. It sits between the datapath's memory stage and the memory/peripheral blocks. It is the splitting counterpart of the 2:1 32-bit select muxes in the datapath.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- SEL_BIT, 31, address bit choosing slave (0 → s0, 1 → s1)
- TIMEOUT_CYCLES, 255, BUSY cycles before error (timeout build only; ≥1)

- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- cpuReq  in  1  request; held high until cpuAck
- cpuWe  in  1  1 = store, 0 = load
- cpuAddr  in  ADDR_W  request address
- cpuWdata  in  DATA_W  store data
- cpuAck  out  1  one-cycle completion pulse
- cpuRdata  out  DATA_W  load data, valid while cpuAck=1; 0 otherwise and on stores
- cpuErr  out  1  with cpuAck: transaction timed out
- s0Req / s1Req  out  1  slave request, registered
- s0We / s1We  out  1  registered copy of cpuWe
- s0Addr / s1Addr  out  ADDR_W  registered copy of cpuAddr
- s0Wdata / s1Wdata  out  DATA_W  registered copy of cpuWdata
- s0Ack / s1Ack  in  1  slave done; qualifies sXRdata
- s0Rdata / s1Rdata  in  DATA_W  slave read data

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: on cpuReq=1, capture we/addr/wdata, set sel=cpuAddr[SEL_BIT], go to BUSY. Capture registers drive both slaves' We/Addr/Wdata; only the selected sXReq asserts.
- BUSY: selected sXReq=1. On selected sXAck=1, capture sXRdata (loads; 0 on stores), drop sXReq, go to RESP. Ack from the unselected slave is ignored.
- RESP: cpuAck=1 for exactly one cycle, cpuRdata=captured data, go to IDLE.
- cpuReq high in the cycle after cpuAck is a new transaction. The requester drops cpuReq in the cpuAck cycle to avoid this.
- cpuAddr/cpuWe/cpuWdata are sampled only at the IDLE→BUSY edge. Later changes have no effect.
- Any sXAck seen outside BUSY is ignored.
- Reset values: state IDLE; cpuAck, cpuErr, s0Req, s1Req = 0; all data/address/We outputs = 0.
- Reset during BUSY or RESP: the transaction is dropped, no cpuAck is issued, and sXReq is 0 the next cycle.

## Timing
- The cpuReq cycle is T0. sXReq is high from T1.
- With a slave ack in T1, cpuAck is high in T2. Minimum latency is 2 cycles.
- Latency = 2 + slave wait cycles.
- One transaction in flight at a time. Throughput is at best one transaction per 3 cycles (IDLE/BUSY/RESP).
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- DATA_BUS_DEMUX_TIMEOUT_EN defined:
  - BUSY counter starts at 0 on BUSY entry and increments each BUSY cycle without an ack.
  - When it reaches TIMEOUT_CYCLES, drop sXReq, go to RESP with cpuErr=1 and cpuRdata=0.
  - If an ack arrives in the expiry cycle, the ack wins: normal completion, cpuErr=0.
- Macro undefined:
  - No counter; BUSY waits indefinitely.
  - cpuErr is tied to 0.

## Structure
- Package data_bus_demux_pkg holds:
  - state typedef (IDLE=2'd0, BUSY=2'd1, RESP=2'd2)
  - default width constants ADDR_W/DATA_W
- Sub-module bus_timeout_counter (clear, enable, expired output) is instantiated only under DATA_BUS_DEMUX_TIMEOUT_EN.

## Test plan
- Load, s0 path: cpuAddr=0x0000_0010, cpuWe=0, s0 acks in T1 with 0xDEADBEEF → s1Req never high; cpuAck at T2, cpuRdata=0xDEADBEEF.
- Store, s1 path: cpuAddr=0x8000_0004, cpuWdata=0x1234_5678, s1 acks after 3 wait cycles → s1Wdata=0x12345678 while s1Req is high; cpuAck at T5, cpuRdata=0.
- Stray ack: s1Ack=1 during an s0 transaction and s0Ack=1 in IDLE → ignored; completion only on s0Ack.
- Back-to-back: cpuReq held high through cpuAck → second transaction captured in the following IDLE cycle; exactly two cpuAck pulses.
- Reset mid-BUSY: assert reset with s0Req high → next cycle all outputs 0; no cpuAck; a later ack is ignored.
- Timeout (macro on, TIMEOUT_CYCLES=4): no slave ack → cpuAck with cpuErr=1 and cpuRdata=0. Repeat with ack in the expiry cycle → cpuErr=0 and data returned.

Source files
------------

// File: rtl/data_bus_demux_pkg.sv
// Shared types and default widths for the CPU data-bus demultiplexer.
package data_bus_demux_pkg;

   localparam int ADDR_W_DFLT = 32;
   localparam int DATA_W_DFLT = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/data_bus_demux_timeout_counter.sv
// BUSY-phase watchdog: counts waited cycles from 0 and flags the last permitted one.
module bus_timeout_counter #(
   parameter int LIMIT = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(LIMIT + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] count_q, count_d;

   // Saturate on the expiry value; the FSM leaves BUSY in that same cycle.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && (count_q != LAST)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = (count_q == LAST);

endmodule

// File: rtl/data_bus_demux.sv
// Routes one CPU load/store to data memory (s0) or I/O (s1) by one address bit.
// Optional BUSY watchdog enabled by defining DATA_BUS_DEMUX_TIMEOUT_EN.
module data_bus_demux
   import data_bus_demux_pkg::*;
#(
   parameter int ADDR_W         = ADDR_W_DFLT,
   parameter int DATA_W         = DATA_W_DFLT,
   parameter int SEL_BIT        = 31,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpuReq,
   input  logic              cpuWe,
   input  logic [ADDR_W-1:0] cpuAddr,
   input  logic [DATA_W-1:0] cpuWdata,
   output logic              cpuAck,
   output logic [DATA_W-1:0] cpuRdata,
   output logic              cpuErr,
   output logic              s0Req,
   output logic              s0We,
   output logic [ADDR_W-1:0] s0Addr,
   output logic [DATA_W-1:0] s0Wdata,
   input  logic              s0Ack,
   input  logic [DATA_W-1:0] s0Rdata,
   output logic              s1Req,
   output logic              s1We,
   output logic [ADDR_W-1:0] s1Addr,
   output logic [DATA_W-1:0] s1Wdata,
   input  logic              s1Ack,
   input  logic [DATA_W-1:0] s1Rdata
);

   if (SEL_BIT >= ADDR_W || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("data_bus_demux: SEL_BIT must be below ADDR_W and TIMEOUT_CYCLES at least 1");
   end

   state_e            state_q, state_d;
   logic              sel_q, sel_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              s0_req_q, s0_req_d;
   logic              s1_req_q, s1_req_d;
   logic              ack_q, ack_d;
   logic              sel_ack;
   logic [DATA_W-1:0] sel_rdata;
   logic              expired;

   assign sel_ack   = sel_q ? s1Ack   : s0Ack;
   assign sel_rdata = sel_q ? s1Rdata : s0Rdata;

`ifdef DATA_BUS_DEMUX_TIMEOUT_EN
   logic err_q, err_d;

   bus_timeout_counter #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_timeout (
      .clock    (clock),
      .reset    (reset),
      .clear_i  (state_q != BUSY),
      .enable_i ((state_q == BUSY) && !sel_ack),
      .expired_o(expired)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign cpuErr = err_q;
`else
   assign expired = 1'b0;
   assign cpuErr  = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = '0;
      s0_req_d = 1'b0;
      s1_req_d = 1'b0;
      ack_d    = 1'b0;
`ifdef DATA_BUS_DEMUX_TIMEOUT_EN
      err_d    = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (cpuReq) begin
               state_d  = BUSY;
               sel_d    = cpuAddr[SEL_BIT];
               we_d     = cpuWe;
               addr_d   = cpuAddr;
               wdata_d  = cpuWdata;
               s0_req_d = !cpuAddr[SEL_BIT];
               s1_req_d = cpuAddr[SEL_BIT];
            end
         end
         BUSY: begin
            // A real ack beats an expiry landing in the same cycle.
            if (sel_ack) begin
               state_d = RESP;
               ack_d   = 1'b1;
               rdata_d = we_q ? '0 : sel_rdata;
            end else if (expired) begin
               state_d = RESP;
               ack_d   = 1'b1;
`ifdef DATA_BUS_DEMUX_TIMEOUT_EN
               err_d   = 1'b1;
`endif
            end else begin
               s0_req_d = !sel_q;
               s1_req_d = sel_q;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         sel_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         s0_req_q <= 1'b0;
         s1_req_q <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         s0_req_q <= s0_req_d;
         s1_req_q <= s1_req_d;
         ack_q    <= ack_d;
      end
   end

   assign cpuAck   = ack_q;
   assign cpuRdata = rdata_q;
   assign s0Req    = s0_req_q;
   assign s1Req    = s1_req_q;
   assign s0We     = we_q;
   assign s1We     = we_q;
   assign s0Addr   = addr_q;
   assign s1Addr   = addr_q;
   assign s0Wdata  = wdata_q;
   assign s1Wdata  = wdata_q;

endmodule

// File: tb/tb_data_bus_demux.sv
// Self-checking bench for data_bus_demux: vector table, random transactions, corner sequences.
module tb_data_bus_demux;

`ifdef DATA_BUS_DEMUX_TIMEOUT_EN
   localparam int TB_TO = 4;
`else
   localparam int TB_TO = 255;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        cpuReq, cpuWe;
   logic [31:0] cpuAddr, cpuWdata;
   logic        cpuAck, cpuErr;
   logic [31:0] cpuRdata;
   logic        s0Req, s0We, s0Ack, s1Req, s1We, s1Ack;
   logic [31:0] s0Addr, s0Wdata, s0Rdata, s1Addr, s1Wdata, s1Rdata;

   int n_checks = 0;
   int n_fail   = 0;
   int to_got;

   data_bus_demux #(
      .ADDR_W(32), .DATA_W(32), .SEL_BIT(31), .TIMEOUT_CYCLES(TB_TO)
   ) dut (
      .clock(clock), .reset(reset),
      .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWdata(cpuWdata),
      .cpuAck(cpuAck), .cpuRdata(cpuRdata), .cpuErr(cpuErr),
      .s0Req(s0Req), .s0We(s0We), .s0Addr(s0Addr), .s0Wdata(s0Wdata),
      .s0Ack(s0Ack), .s0Rdata(s0Rdata),
      .s1Req(s1Req), .s1We(s1We), .s1Addr(s1Addr), .s1Wdata(s1Wdata),
      .s1Ack(s1Ack), .s1Rdata(s1Rdata)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waitc;
      logic [31:0] sdata;
      bit          stray;
      logic [31:0] exp_rd;
      int          exp_lat;
   } vec_t;

   vec_t vecs[6];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Transaction-level model: the selected slave sees the captured request from T1,
   // acks after waitc wait cycles, and the CPU sees one ack pulse at T(2+waitc).
   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waitc, input logic [31:0] sdata, input bit stray,
                          input logic [31:0] exp_rd, input int exp_lat, input string tag);
      bit sel;
      int got;
      sel = addr[31];
      got = -1;
      cpuReq = 1'b1; cpuWe = we; cpuAddr = addr; cpuWdata = wdata;
      check({tag, " ack_t0"}, cpuAck, 0);
      for (int c = 1; c <= exp_lat + 20 && got < 0; c++) begin
         step();
         cpuAddr = $urandom; cpuWdata = $urandom; cpuWe = 1'($urandom);
         if (cpuAck) begin
            got = c;
            check({tag, " rdata"}, cpuRdata, exp_rd);
            check({tag, " err"}, cpuErr, 0);
            check({tag, " reqs_resp"}, {s0Req, s1Req}, 0);
            cpuReq = 1'b0;
            s0Ack = stray; s1Ack = stray;
         end else begin
            check({tag, " sel_req"}, sel ? s1Req : s0Req, 1);
            check({tag, " unsel_req"}, sel ? s0Req : s1Req, 0);
            check({tag, " port_addr"}, sel ? s1Addr : s0Addr, addr);
            check({tag, " port_we"}, sel ? s1We : s0We, we);
            check({tag, " port_wdata"}, sel ? s1Wdata : s0Wdata, wdata);
            if (sel) begin
               s1Ack = (c == waitc + 1); s1Rdata = (c == waitc + 1) ? sdata : $urandom;
               s0Ack = stray ? 1'($urandom) : 1'b0; s0Rdata = $urandom;
            end else begin
               s0Ack = (c == waitc + 1); s0Rdata = (c == waitc + 1) ? sdata : $urandom;
               s1Ack = stray ? 1'($urandom) : 1'b0; s1Rdata = $urandom;
            end
         end
      end
      check({tag, " latency"}, got, exp_lat);
      step();
      check({tag, " ack_pulse_end"}, cpuAck, 0);
      check({tag, " rdata_idle"}, cpuRdata, 0);
      check({tag, " reqs_idle"}, {s0Req, s1Req}, 0);
      s0Ack = 1'b0; s1Ack = 1'b0;
   endtask

   initial begin
      int acks;
      logic        rw;
      logic [31:0] ra, rd, rs;
      int          rwait;

      vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 2};
      vecs[1] = '{1'b1, 32'h8000_0004, 32'h1234_5678, 3, 32'hFFFF_0000, 1'b0, 32'h0,         5};
      vecs[2] = '{1'b0, 32'h7FFF_FFFC, 32'h0,         2, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D, 4};
      vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 1, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 3};
      vecs[4] = '{1'b1, 32'h0000_0000, 32'h5555_5555, 0, 32'h1111_1111, 1'b1, 32'h0,         2};
      vecs[5] = '{1'b0, 32'h8000_0000, 32'h0,         7, 32'h0000_0001, 1'b1, 32'h0000_0001, 9};

      reset = 1'b1; cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWdata = '0;
      s0Ack = 1'b0; s1Ack = 1'b0; s0Rdata = '0; s1Rdata = '0;
      step(); step();
      check("reset_ack", cpuAck, 0);
      check("reset_err", cpuErr, 0);
      check("reset_reqs", {s0Req, s1Req}, 0);
      check("reset_we", {s0We, s1We}, 0);
      check("reset_addr", {s0Addr, s1Addr}, 0);
      check("reset_wdata", {s0Wdata, s1Wdata}, 0);
      check("reset_rdata", cpuRdata, 0);
      reset = 1'b0;
      step();

      // Acks in IDLE must not start or complete anything.
      s0Ack = 1'b1; s1Ack = 1'b1; s0Rdata = 32'h1; s1Rdata = 32'h2;
      step();
      s0Ack = 1'b0; s1Ack = 1'b0;
      check("idle_ack_cpuack", cpuAck, 0);
      check("idle_ack_reqs", {s0Req, s1Req}, 0);
      step();
      check("idle_ack_cpuack2", cpuAck, 0);

      for (int i = 0; i < 6; i++) begin
         run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].waitc, vecs[i].sdata,
                 vecs[i].stray, vecs[i].exp_rd, vecs[i].exp_lat, $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 30; i++) begin
         rw = 1'($urandom); ra = $urandom; rd = $urandom; rs = $urandom;
         rwait = int'($urandom_range(0, 5));
         run_txn(rw, ra, rd, rwait, rs, 1'($urandom), rw ? 32'h0 : rs, 2 + rwait,
                 $sformatf("rnd%0d", i));
      end

      // Back-to-back: cpuReq held through the first ack starts a second transaction.
      acks = 0;
      for (int c = 0; c <= 8; c++) begin
         if (c > 0) step();
         if (cpuAck) acks++;
         case (c)
            0: begin cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 32'h0000_0010; end
            1: begin check("b2b_s0req", s0Req, 1); s0Ack = 1'b1; s0Rdata = 32'hAAAA_0001; end
            2: begin
               s0Ack = 1'b0;
               check("b2b_ack1", cpuAck, 1);
               check("b2b_rd1", cpuRdata, 32'hAAAA_0001);
               cpuAddr = 32'h8000_0020;
            end
            3: check("b2b_gap", {cpuAck, s0Req, s1Req}, 0);
            4: begin
               check("b2b_s1req", s1Req, 1);
               check("b2b_s1addr", s1Addr, 32'h8000_0020);
               s1Ack = 1'b1; s1Rdata = 32'h5555_0002;
            end
            5: begin
               s1Ack = 1'b0; cpuReq = 1'b0;
               check("b2b_ack2", cpuAck, 1);
               check("b2b_rd2", cpuRdata, 32'h5555_0002);
            end
            default: ;
         endcase
      end
      check("b2b_ack_count", acks, 2);

      // Reset while BUSY drops the transaction; a late ack is ignored.
      cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 32'h0000_0040; cpuWdata = 32'hFEED_0001;
      step();
      check("rst_busy_s0req", s0Req, 1);
      reset = 1'b1; cpuReq = 1'b0;
      step();
      reset = 1'b0;
      check("rst_busy_reqs", {s0Req, s1Req}, 0);
      check("rst_busy_ack", cpuAck, 0);
      check("rst_busy_port", {s0We, s0Addr, s0Wdata}, 0);
      s0Ack = 1'b1; s0Rdata = 32'h9999_9999;
      step();
      s0Ack = 1'b0;
      check("rst_late_ack", {cpuAck, s0Req}, 0);
      step();
      check("rst_late_ack2", {cpuAck, cpuRdata}, 0);

`ifdef DATA_BUS_DEMUX_TIMEOUT_EN
      to_got = -1;
      cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 32'h0000_0100;
      for (int c = 1; c <= 20 && to_got < 0; c++) begin
         step();
         if (cpuAck) begin
            to_got = c;
            check("to_err", cpuErr, 1);
            check("to_rdata", cpuRdata, 0);
            cpuReq = 1'b0;
         end
      end
      check("to_latency", to_got, TB_TO + 1);
      step();
      check("to_err_clear", {cpuAck, cpuErr}, 0);
      run_txn(1'b0, 32'h8000_0100, 32'h0, TB_TO - 1, 32'h7777_1234, 1'b0,
              32'h7777_1234, TB_TO + 1, "to_ack_wins");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
